// File: rtl/knight_move_collector.sv
// knight_move_collector: walks the 8 knight directions for one square through
// the knight spot scanner and builds a legal-destination mask and move count.
// Optional build macro: KNIGHT_CAPTURE_MASK_EN adds the capture_mask output.
//
// state | meaning
// IDLE  | waiting for start; results of the last scan held
// ISSUE | scan_direction presented to the scanner
// WAIT  | extra scanner latency cycles (SCAN_LATENCY-1)
// EVAL  | scanner result sampled and folded into the mask
// DONE  | one-cycle done pulse
module knight_move_collector #(
    parameter int SCAN_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  square,
    input  logic        side,
    output logic [5:0]  scan_position,
    output logic [2:0]  scan_direction,
    input  logic [5:0]  scan_pos_in,
    input  logic [3:0]  scan_piece_in,
    output logic        busy,
    output logic        done,
    output logic [63:0] move_mask,
    output logic [3:0]  move_count,
    output logic        scan_err
`ifdef KNIGHT_CAPTURE_MASK_EN
    ,
    output logic [63:0] capture_mask
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_EVAL, S_DONE} state_t;

    localparam int WAIT_LOAD = (SCAN_LATENCY > 1) ? SCAN_LATENCY - 2 : 0;

    state_t      state, state_nxt;
    logic [7:0]  wait_cnt;
    logic        side_q;
    logic [2:0]  file, rank;
    logic [6:0]  offset;
    logic [6:0]  target;
    logic        tgt_ok;
    logic        pos_match;
    logic        own_piece;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = (SCAN_LATENCY > 1) ? S_WAIT : S_EVAL;
            S_WAIT:  if (wait_cnt == 8'd0) state_nxt = S_EVAL;
            S_EVAL:  state_nxt = (scan_direction == 3'd7) ? S_DONE : S_ISSUE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state == S_ISSUE) || (state == S_WAIT) || (state == S_EVAL);
    assign done = (state == S_DONE);

    // Target square and on-board check; invalid targets never reach the mask so no wrap
    always_comb begin
        file   = scan_position[2:0];
        rank   = scan_position[5:3];
        offset = 7'd0;
        tgt_ok = 1'b0;
        case (scan_direction)
            3'd0: begin offset = -7'sd17; tgt_ok = (file >= 3'd1) && (rank >= 3'd2); end
            3'd1: begin offset = -7'sd10; tgt_ok = (file >= 3'd2) && (rank >= 3'd1); end
            3'd2: begin offset =  7'sd6;  tgt_ok = (file >= 3'd2) && (rank <= 3'd6); end
            3'd3: begin offset =  7'sd15; tgt_ok = (file >= 3'd1) && (rank <= 3'd5); end
            3'd4: begin offset =  7'sd17; tgt_ok = (file <= 3'd6) && (rank <= 3'd5); end
            3'd5: begin offset =  7'sd10; tgt_ok = (file <= 3'd5) && (rank <= 3'd6); end
            3'd6: begin offset = -7'sd6;  tgt_ok = (file <= 3'd5) && (rank >= 3'd1); end
            default: begin offset = -7'sd15; tgt_ok = (file <= 3'd6) && (rank >= 3'd2); end
        endcase
        target    = {1'b0, scan_position} + offset;
        pos_match = (scan_pos_in == target[5:0]);
        own_piece = (scan_piece_in != 4'd0) && (scan_piece_in[3] == side_q);
    end

    // Capture, direction stepping, latency timer and result accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_position  <= 6'd0;
            scan_direction <= 3'd0;
            side_q         <= 1'b0;
            wait_cnt       <= 8'd0;
            move_mask      <= 64'd0;
            move_count     <= 4'd0;
            scan_err       <= 1'b0;
`ifdef KNIGHT_CAPTURE_MASK_EN
            capture_mask   <= 64'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        scan_position  <= square;
                        side_q         <= side;
                        scan_direction <= 3'd0;
                        move_mask      <= 64'd0;
                        move_count     <= 4'd0;
                        scan_err       <= 1'b0;
`ifdef KNIGHT_CAPTURE_MASK_EN
                        capture_mask   <= 64'd0;
`endif
                    end
                end
                S_ISSUE: wait_cnt <= WAIT_LOAD[7:0];
                S_WAIT:  if (wait_cnt != 8'd0) wait_cnt <= wait_cnt - 8'd1;
                S_EVAL: begin
                    if (tgt_ok) begin
                        if (!pos_match) begin
                            scan_err <= 1'b1;
                        end else if (!own_piece) begin
                            move_mask[target[5:0]] <= 1'b1;
                            move_count             <= move_count + 4'd1;
`ifdef KNIGHT_CAPTURE_MASK_EN
                            if (scan_piece_in != 4'd0) capture_mask[target[5:0]] <= 1'b1;
`endif
                        end
                    end
                    if (scan_direction != 3'd7) scan_direction <= scan_direction + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_knight_move_collector.sv
// Scoreboard bench for knight_move_collector with a latency-1 scanner model.
module tb_knight_move_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  square = 6'd0;
    logic        side = 1'b0;
    logic [5:0]  scan_position;
    logic [2:0]  scan_direction;
    logic [5:0]  scan_pos_in = 6'd0;
    logic [3:0]  scan_piece_in = 4'd0;
    logic        busy, done;
    logic [63:0] move_mask;
    logic [3:0]  move_count;
    logic        scan_err;
`ifdef KNIGHT_CAPTURE_MASK_EN
    logic [63:0] capture_mask;
`endif

    knight_move_collector #(.SCAN_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .start(start), .square(square), .side(side),
        .scan_position(scan_position), .scan_direction(scan_direction),
        .scan_pos_in(scan_pos_in), .scan_piece_in(scan_piece_in),
        .busy(busy), .done(done), .move_mask(move_mask),
        .move_count(move_count), .scan_err(scan_err)
`ifdef KNIGHT_CAPTURE_MASK_EN
        , .capture_mask(capture_mask)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scanner model: board lookup by file/rank steps, one cycle latency
    logic [3:0] board [64];
    logic       stale_en = 1'b0;
    int df_tab [8] = '{-1, -2, -2, -1, 1, 2, 2, 1};
    int dr_tab [8] = '{-2, -1, 1, 2, 2, 1, -1, -2};
    int nf, nr;
    always_comb begin
        nf = int'(scan_position[2:0]) + df_tab[scan_direction];
        nr = int'(scan_position[5:3]) + dr_tab[scan_direction];
    end
    always @(posedge clk) begin
        if (stale_en && scan_direction == 3'd4) begin
            scan_pos_in   <= scan_pos_in;
            scan_piece_in <= scan_piece_in;
        end else if (nf >= 0 && nf < 8 && nr >= 0 && nr < 8) begin
            scan_pos_in   <= 6'(nr * 8 + nf);
            scan_piece_in <= board[nr * 8 + nf];
        end else begin
            scan_pos_in   <= 6'd0;
            scan_piece_in <= 4'd0;
        end
    end

    typedef struct {
        logic [63:0] mask;
        logic [3:0]  cnt;
        logic        err;
        logic [63:0] cap;
        int          acc;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pop expected result whenever done pulses
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("move_mask", move_mask, e.mask);
                chk("move_count", 64'(move_count), 64'(e.cnt));
                chk("scan_err", 64'(scan_err), 64'(e.err));
                chk("done_cycle", 64'(cyc - e.acc), 64'd16);
                chk("busy_at_done", 64'(busy), 64'd0);
`ifdef KNIGHT_CAPTURE_MASK_EN
                chk("capture_mask", capture_mask, e.cap);
`endif
            end
        end
    end

    task automatic clear_board();
        for (int i = 0; i < 64; i++) board[i] = 4'd0;
    endtask

    task automatic start_scan(input logic [5:0] sq, input logic sd, input logic [63:0] m,
                              input logic [3:0] c, input logic e, input logic [63:0] cp);
        exp_t x;
        @(negedge clk);
        start = 1'b1; square = sq; side = sd;
        @(negedge clk);
        start = 1'b0;
        x.mask = m; x.cnt = c; x.err = e; x.cap = cp; x.acc = cyc;
        exp_q.push_back(x);
        chk("busy_after_accept", 64'(busy), 64'd1);
    endtask

    task automatic wait_results();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    localparam logic [63:0] M_SQ0  = (64'd1 << 10) | (64'd1 << 17);
    localparam logic [63:0] M_SQ27 = (64'd1 << 10) | (64'd1 << 12) | (64'd1 << 17) | (64'd1 << 21) |
                                     (64'd1 << 33) | (64'd1 << 37) | (64'd1 << 42) | (64'd1 << 44);
    localparam logic [63:0] M_NO44 = M_SQ27 & ~(64'd1 << 44);

    initial begin
        clear_board();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mask", move_mask, 64'd0);
        chk("rst_count", 64'(move_count), 64'd0);
        chk("rst_busy_done", 64'({busy, done, scan_err}), 64'd0);
        chk("rst_scan_io", 64'({scan_position, scan_direction}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        start_scan(6'd0, 1'b0, M_SQ0, 4'd2, 1'b0, 64'd0);
        wait_results();

        start_scan(6'd27, 1'b0, M_SQ27, 4'd8, 1'b0, 64'd0);
        wait_results();

        board[44] = 4'b0001;
        board[10] = 4'b1001;
        start_scan(6'd27, 1'b0, M_NO44, 4'd7, 1'b0, 64'd1 << 10);
        wait_results();
        clear_board();

        stale_en = 1'b1;
        start_scan(6'd27, 1'b0, M_NO44, 4'd7, 1'b1, 64'd0);
        wait_results();
        stale_en = 1'b0;

        start_scan(6'd27, 1'b0, M_SQ27, 4'd8, 1'b0, 64'd0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_mask", move_mask, 64'd0);
        chk("midrst_count_err", 64'({move_count, scan_err}), 64'd0);
        chk("midrst_busy_done", 64'({busy, done}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        start_scan(6'd0, 1'b0, M_SQ0, 4'd2, 1'b0, 64'd0);
        wait_results();

        start_scan(6'd27, 1'b0, M_SQ27, 4'd8, 1'b0, 64'd0);
        square = 6'd63; side = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("repulse_position", 64'(scan_position), 64'd27);
        wait_results();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
